mult_adder_seq: RTL and testbench

Sequential responder for the 128-lane multiply-add operand interface driven by the fully connected layers. It accepts two packed sign-magnitude operand vectors and computes their dot product in fixed-point sign-magnitude, processing `PAR` lanes per cycle. It returns a saturated `2*BIT-1`-bit result with an overflow flag. An explicit start/valid handshake replaces the fixed single-cycle assumption, so layer controllers wait on `oValid` before consuming the result.

---
 rtl/mult_adder_seq.sv | 119 +++++++++++
 tb/tb_mult_adder_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_adder_seq.sv
// Sequential sign-magnitude dot product over LANES operand pairs, PAR lanes per beat.
// Result is clipped to 2*BIT-1 sign-magnitude bits with a per-result overflow flag.

module mult_adder_lane #(
    parameter int BIT = 8
) (
    input  logic [BIT-1:0]   opr1,
    input  logic [BIT-1:0]   opr2,
    output logic [2*BIT-2:0] prod
);
    logic [2*BIT-3:0] mag;
    logic             neg;

    assign mag  = {{(BIT-1){1'b0}}, opr1[BIT-2:0]} * {{(BIT-1){1'b0}}, opr2[BIT-2:0]};
    // A zero magnitude is always +0, whatever the operand signs say.
    assign neg  = (opr1[BIT-1] ^ opr2[BIT-1]) && (mag != '0);
    assign prod = neg ? -{1'b0, mag} : {1'b0, mag};
endmodule

module mult_adder_seq #(
    parameter int BIT   = 8,
    parameter int LANES = 128,
    parameter int PAR   = 8
) (
    input  logic                 clk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic [LANES*BIT-1:0] iOpr1,
    input  logic [LANES*BIT-1:0] iOpr2,
    output logic                 oBusy,
    output logic                 oValid,
    output logic [2*BIT-2:0]     oResult,
    output logic                 oOverflow
);
    localparam int N  = LANES / PAR;
    localparam int PW = 2*BIT - 1;
    localparam int MW = 2*BIT - 2;
    localparam int AW = PW + $clog2(LANES) + 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] MAXM = {{(AW-MW){1'b0}}, {MW{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACC, NORM} state_t;

    state_t                     state;
    logic [BW-1:0]              beat;
    logic [LANES-1:0][BIT-1:0]  opr1_q, opr2_q;
    logic [PAR-1:0][PW-1:0]     prod;
    logic signed [AW-1:0]       acc, beat_sum;
    logic [AW-1:0]              acc_abs;
    logic                       ovf_n;
    logic [PW-1:0]              res_n;

    // Operand registers shift down by PAR lanes each beat, so the lanes
    // being consumed always sit in the low PAR slots.
    for (genvar g = 0; g < PAR; g++) begin : g_lane
        mult_adder_lane #(.BIT(BIT)) u_lane (
            .opr1 (opr1_q[g]),
            .opr2 (opr2_q[g]),
            .prod (prod[g])
        );
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < PAR; i++)
            beat_sum = beat_sum + AW'($signed(prod[i]));
    end

    always_comb begin
        acc_abs = acc[AW-1] ? AW'(-acc) : AW'(acc);
        ovf_n   = acc_abs > MAXM;
        res_n   = {acc[AW-1], ovf_n ? {MW{1'b1}} : acc_abs[MW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state     <= IDLE;
            beat      <= '0;
            acc       <= '0;
            opr1_q    <= '0;
            opr2_q    <= '0;
            oBusy     <= 1'b0;
            oValid    <= 1'b0;
            oResult   <= '0;
            oOverflow <= 1'b0;
        end else begin
            oValid <= 1'b0;
            case (state)
                IDLE: if (iStart) begin
                    opr1_q <= iOpr1;
                    opr2_q <= iOpr2;
                    acc    <= '0;
                    beat   <= '0;
                    oBusy  <= 1'b1;
                    state  <= ACC;
                end
                ACC: begin
                    acc    <= acc + beat_sum;
                    opr1_q <= opr1_q >> (PAR*BIT);
                    opr2_q <= opr2_q >> (PAR*BIT);
                    beat   <= beat + 1'b1;
                    if (beat == BW'(N-1))
                        state <= NORM;
                end
                NORM: begin
                    oResult   <= res_n;
                    oOverflow <= ovf_n;
                    oValid    <= 1'b1;
                    oBusy     <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_adder_seq.sv
// Scoreboard bench for mult_adder_seq: directed vectors push expected results,
// a negedge monitor pops and compares on every oValid.

module tb_mult_adder_seq;
    localparam int BIT   = 8;
    localparam int LANES = 128;
    localparam int PAR   = 8;
    localparam int RW    = 2*BIT - 1;

    logic                 clk = 1'b0;
    logic                 iRst_n;
    logic                 iStart;
    logic [LANES*BIT-1:0] iOpr1, iOpr2;
    logic                 oBusy, oValid, oOverflow;
    logic [RW-1:0]        oResult;

    int checks = 0;
    int fails  = 0;
    int valid_cnt = 0;
    logic [RW:0] exp_q[$];

    mult_adder_seq #(.BIT(BIT), .LANES(LANES), .PAR(PAR)) dut (
        .clk       (clk),
        .iRst_n    (iRst_n),
        .iStart    (iStart),
        .iOpr1     (iOpr1),
        .iOpr2     (iOpr2),
        .oBusy     (oBusy),
        .oValid    (oValid),
        .oResult   (oResult),
        .oOverflow (oOverflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (iRst_n && oValid) begin
            logic [RW:0] e;
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid: got result 0x%0h with no request pending", oResult);
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'(oResult), 32'(e[RW-1:0]));
                chk("overflow", 32'(oOverflow), 32'(e[RW]));
                chk("busy_on_valid", 32'(oBusy), 32'd0);
            end
        end
    end

    // Caller is at a negedge; start is captured on the following posedge.
    task automatic start_req(input logic [LANES*BIT-1:0] a, input logic [LANES*BIT-1:0] b,
                             input logic [RW-1:0] er, input logic eo);
        iOpr1  = a;
        iOpr2  = b;
        iStart = 1'b1;
        exp_q.push_back({eo, er});
        @(negedge clk);
        iStart = 1'b0;
        iOpr1  = {LANES{8'hA5}};
        iOpr2  = {LANES{8'h5A}};
    endtask

    task automatic wait_result(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        while (!oValid && lat < 40) begin
            if (oBusy) busy++;
            @(negedge clk);
            lat++;
        end
        if (!oValid) begin
            checks++;
            fails++;
            $display("FAIL valid_timeout: got no oValid within %0d cycles expected one", lat);
        end
    endtask

    task automatic lane_vec(output logic [LANES-1:0][BIT-1:0] v, input int lane, input logic [BIT-1:0] val);
        v = '0;
        v[lane] = val;
    endtask

    initial begin
        logic [LANES-1:0][BIT-1:0] a, b;
        int lat, busy, vc;

        iRst_n = 1'b0;
        iStart = 1'b0;
        iOpr1  = '0;
        iOpr2  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_result", 32'(oResult), 0);
        chk("rst_overflow", 32'(oOverflow), 0);
        iRst_n = 1'b1;
        @(negedge clk);

        // Single lane: latency and busy width.
        lane_vec(a, 0, 8'h05); lane_vec(b, 0, 8'h03);
        start_req(a, b, 15'h000F, 1'b0);
        wait_result(lat, busy);
        chk("latency", 32'(lat), 17);
        chk("busy_cycles", 32'(busy), 17);
        repeat (3) @(negedge clk);
        chk("result_hold", 32'(oResult), 32'h000F);
        chk("valid_pulse", 32'(oValid), 0);

        lane_vec(a, 0, 8'h85); lane_vec(b, 0, 8'h03);
        start_req(a, b, 15'h400F, 1'b0);
        wait_result(lat, busy);
        @(negedge clk);

        lane_vec(a, 0, 8'h80); lane_vec(b, 0, 8'h05);
        start_req(a, b, 15'h0000, 1'b0);
        wait_result(lat, busy);
        @(negedge clk);

        // Cancellation across lanes in different beats.
        a = '0; b = '0;
        a[0] = 8'h7F; b[0] = 8'h7F; a[100] = 8'hFF; b[100] = 8'h7F;
        start_req(a, b, 15'h0000, 1'b0);
        wait_result(lat, busy);
        @(negedge clk);

        start_req({LANES{8'h7F}}, {LANES{8'h7F}}, 15'h3FFF, 1'b1);
        wait_result(lat, busy);
        @(negedge clk);
        start_req({LANES{8'hFF}}, {LANES{8'h7F}}, 15'h7FFF, 1'b1);
        wait_result(lat, busy);
        @(negedge clk);
        lane_vec(a, 5, 8'h05); lane_vec(b, 5, 8'h03);
        start_req(a, b, 15'h000F, 1'b0);
        wait_result(lat, busy);
        @(negedge clk);

        // iStart pulses while busy are dropped.
        vc = valid_cnt;
        lane_vec(a, 127, 8'h82); lane_vec(b, 127, 8'h84);
        start_req(a, b, 15'h0008, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            iStart = (c == 3 || c == 8 || c == 12);
            iOpr1  = {LANES{8'h11}};
            iOpr2  = {LANES{8'h22}};
            @(negedge clk);
        end
        iStart = 1'b0;
        wait_result(lat, busy);
        repeat (25) @(negedge clk);
        chk("ignored_starts", 32'(valid_cnt - vc), 1);

        // Back-to-back: start in the oValid cycle.
        lane_vec(a, 9, 8'h0A); lane_vec(b, 9, 8'h8A);
        start_req(a, b, 15'h4064, 1'b0);
        wait_result(lat, busy);
        lane_vec(a, 64, 8'h7F); lane_vec(b, 64, 8'h02);
        start_req(a, b, 15'h00FE, 1'b0);
        wait_result(lat, busy);
        chk("b2b_latency", 32'(lat), 17);
        @(negedge clk);

        // Reset mid-operation discards the request.
        vc = valid_cnt;
        lane_vec(a, 0, 8'h05); lane_vec(b, 0, 8'h07);
        start_req(a, b, 15'h0023, 1'b0);
        repeat (7) @(negedge clk);
        iRst_n = 1'b0;
        @(negedge clk);
        iRst_n = 1'b1;
        chk("midrst_busy", 32'(oBusy), 0);
        chk("midrst_valid", 32'(oValid), 0);
        chk("midrst_result", 32'(oResult), 0);
        chk("midrst_overflow", 32'(oOverflow), 0);
        void'(exp_q.pop_back());
        repeat (30) @(negedge clk);
        chk("midrst_no_valid", 32'(valid_cnt - vc), 0);
        lane_vec(a, 33, 8'h86); lane_vec(b, 33, 8'h07);
        start_req(a, b, 15'h402A, 1'b0);
        wait_result(lat, busy);
        chk("postrst_latency", 32'(lat), 17);
        repeat (3) @(negedge clk);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end
endmodule
